// File: rtl/leaf_spine_uplink_if.sv
// Source-side and spine-side signal bundle for the leaf uplink injector.
// master drives flits and credit returns; slave is the uplink block itself.
interface leaf_spine_uplink_if #(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned NUM_SRC = 4
);
    logic [NUM_SRC*DWIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [DWIDTH-1:0]         up_data;
    logic                      up_valid;
    logic                      credit_ret;

    modport master (
        output src_data,
        output src_valid,
        output credit_ret,
        input  src_ready,
        input  up_data,
        input  up_valid
    );

    modport slave (
        input  src_data,
        input  src_valid,
        input  credit_ret,
        output src_ready,
        output up_data,
        output up_valid
    );
endinterface

// File: rtl/leaf_spine_uplink.sv
// Round-robin injector from NUM_SRC local sources onto one spine uplink, with
// credit-based flow control against the spine port input FIFO.
module leaf_spine_uplink #(
    parameter logic [3:0]  GROUP_ID   = 4'b0001,
    parameter int unsigned DWIDTH     = 16,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1),
    localparam int unsigned PW        = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     reset,
    leaf_spine_uplink_if.slave       bus,
    output logic [CW-1:0]            credits,
    output logic                     drop_pulse,
    output logic                     cred_err,
    output logic [15:0]              sent_count
);

    logic [PW-1:0]     rr_ptr_q;
    logic [CW-1:0]     credits_q;
    logic [DWIDTH-1:0] up_data_q;
    logic              up_valid_q;
    logic              drop_q;
    logic              cred_err_q;
    logic [15:0]       sent_q;

    logic              found;
    logic [PW-1:0]     win;
    logic [DWIDTH-1:0] win_flit;
    logic              win_drop;
    logic              can_send;
    logic              grant;
    logic              send;
    logic              credit_full;

    // Search from rr_ptr upward with wrap; first requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (!found && bus.src_valid[(int'(rr_ptr_q) + k) % int'(NUM_SRC)]) begin
                found = 1'b1;
                win   = PW'((int'(rr_ptr_q) + k) % int'(NUM_SRC));
            end
        end
    end

    assign win_flit    = bus.src_data[int'(win)*DWIDTH +: DWIDTH];
    assign win_drop    = (win_flit[DWIDTH-1 -: 4] == GROUP_ID);
    assign can_send    = (credits_q != '0);
    assign credit_full = (credits_q == CW'(FIFO_DEPTH));

    // Self-group flits need no credit since they never reach the spine.
    assign grant = found && (can_send || win_drop) && !reset;
    assign send  = grant && !win_drop;

    always_comb begin
        bus.src_ready = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            bus.src_ready[k] = grant && (win == PW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            credits_q  <= CW'(FIFO_DEPTH);
            up_data_q  <= '0;
            up_valid_q <= 1'b0;
            drop_q     <= 1'b0;
            cred_err_q <= 1'b0;
            sent_q     <= '0;
        end else begin
            up_valid_q <= send;
            drop_q     <= grant && win_drop;
            if (send) begin
                up_data_q <= win_flit;
            end
            if (grant) begin
                rr_ptr_q <= (int'(win) == int'(NUM_SRC) - 1) ? '0 : win + 1'b1;
            end
            unique case ({send, bus.credit_ret})
                2'b10: credits_q <= credits_q - 1'b1;
                2'b01: begin
                    if (credit_full) begin
                        cred_err_q <= 1'b1;
                    end else begin
                        credits_q <= credits_q + 1'b1;
                    end
                end
                default: credits_q <= credits_q;
            endcase
            if (send && (sent_q != 16'hFFFF)) begin
                sent_q <= sent_q + 16'd1;
            end
        end
    end

    assign bus.up_data  = up_data_q;
    assign bus.up_valid = up_valid_q;
    assign credits      = credits_q;
    assign drop_pulse   = drop_q;
    assign cred_err     = cred_err_q;
    assign sent_count   = sent_q;

    grant_onehot_a: assert property (@(posedge clk) $onehot0(bus.src_ready));

endmodule

// File: doc/leaf_spine_uplink.md
Name: leaf_spine_uplink

Overview:
- Leaf-side injection stage that sits directly upstream of one leaf port of a spine router, driving its data/valid input pair.
- Round-robin arbitrates single-flit packets from NUM_SRC local sources onto one uplink.
- The spine-side interface is valid-only with no ready, so this block enforces credit-based flow control against the spine port's input FIFO depth and returns backpressure to the sources.

Parameters:
- GROUP_ID, 4'b0001, group of the owning leaf; flits addressed to this group are rejected.
- DWIDTH, 16, flit width.
- NUM_SRC, 4, number of local source ports (2..8).
- FIFO_DEPTH, 8, depth of the downstream spine port input FIFO; initial credit count.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- src_data  input  NUM_SRC*DWIDTH  source flits; source i occupies bits [i*DWIDTH +: DWIDTH]
- src_valid  input  NUM_SRC  source i holds a flit
- src_ready  output  NUM_SRC  one-hot grant; a transfer occurs when valid&ready
- up_data  output  DWIDTH  flit to the spine port
- up_valid  output  1  single-cycle flit strobe to the spine port
- credit_ret  input  1  one pulse per entry freed in the spine port input FIFO
- credits  output  $clog2(FIFO_DEPTH+1)  current credit count
- drop_pulse  output  1  a flit addressed to GROUP_ID was consumed and discarded
- cred_err  output  1  sticky flag: credit return received while credits==FIFO_DEPTH
- sent_count  output  16  saturating count of flits sent on the uplink

Behaviour:
- Reset values: up_data=0, up_valid=0, credits=FIFO_DEPTH, rr_ptr=0, drop_pulse=0, cred_err=0, sent_count=0. src_ready is combinational and is all-zero while reset=1.
- Flit format: dest group is bits [DWIDTH-1:DWIDTH-4]. Payload is opaque.
- Arbitration (combinational, each cycle):
  - can_send = (credits != 0).
  - Search src_valid starting at index rr_ptr, ascending, wrapping modulo NUM_SRC. The first set bit is winner w.
  - src_ready = onehot(w) if any src_valid and (can_send or winner flit is addressed to GROUP_ID); otherwise all zeros.
  - Never more than one src_ready bit is high.
- Transfer at the rising edge with src_valid[w]&src_ready[w]:
  - rr_ptr <= (w+1) mod NUM_SRC.
  - If dest group == GROUP_ID: flit is discarded. drop_pulse<=1 for one cycle, up_valid<=0, no credit is consumed. Drops proceed even when credits==0.
  - Else: up_data<=flit, up_valid<=1 for exactly one cycle, credit consumed, sent_count+1 (saturates at 16'hFFFF).
- No transfer: up_valid<=0, drop_pulse<=0, up_data holds its last value, rr_ptr unchanged.
- Latency: source handshake edge to up_valid is 1 cycle. Throughput is 1 flit/cycle while credits last.
- Credit update per edge:
  - send only: -1.
  - credit_ret only: +1.
  - both: unchanged.
  - credit_ret with credits==FIFO_DEPTH and no send: credits unchanged, cred_err<=1. cred_err clears only on reset.
- Credit boundaries:
  - credits==0: no non-drop grants. Same-edge credit_ret restores credits to 1, and the grant occurs on the following cycle.
  - credits==1 with a send: credits reaches 0 and the next cycle stalls.
- Sources must hold src_valid and src_data stable until granted. A source that lowers valid before its grant just loses priority consideration; this is not an error.
- Reset asserted mid-operation: all state returns to reset values on that edge. A flit in flight on up_valid that edge is cancelled.

Test Plan:
- Single source: reset, src_valid=0001, src_data[0]=16'h2ABC -> src_ready=0001 same cycle; next cycle up_valid=1, up_data=16'h2ABC; credits 8->7; sent_count=1.
- Fairness: all four sources valid continuously, credit_ret pulsed every cycle -> grants in order 0,1,2,3,0,…; up_valid high every cycle; credits stays 8 after the first send/return overlap.
- Credit exhaustion: source 1 valid with 10 flits, no credit_ret -> exactly 8 up_valid pulses; src_ready=0 with credits==0; one credit_ret pulse -> 9th flit sent 1 cycle after the pulse.
- Self-group drop: credits=0, source 2 presents 16'h1005 with GROUP_ID=1 -> granted; drop_pulse=1; up_valid=0; credits stays 0; sent_count unchanged.
- Credit overflow: idle at credits=8, pulse credit_ret -> credits=8, cred_err=1 and stays 1; then reset -> cred_err=0, credits=8.
- Mid-operation reset: reset asserted on the edge where source 3 is granted -> next cycle up_valid=0, rr_ptr=0, credits=8, sent_count=0.
